mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK input 1 rising-edge clock; nRST input 1 async active-low reset.
REQ-002 The CPU data-side ports SHALL be: dREN input 1 data read request; dWEN input 1 data write request; daddr input 32 data byte address; dstore input 32 write data; dwait output 1 data stall; dload output 32 read data.
REQ-003 The CPU instruction-side ports SHALL be: iREN input 1 fetch request; iaddr input 32 fetch address; iwait output 1 fetch stall; iload output 32 instruction word.
REQ-004 The RAM-side ports SHALL be: ramREN output 1; ramWEN output 1; ramaddr output 32; ramstore output 32; ramload input 32; ramstate input 2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-005 The status port SHALL be: err output 1, sticky fault flag.

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, DREQ, DDONE, IREQ, IDONE.
REQ-007 In IDLE, if dREN|dWEN, the block SHALL latch daddr, dstore and op (write if dWEN, else read), then go to DREQ; else if iREN, it SHALL latch iaddr and go to IREQ; else it SHALL stay in IDLE.
REQ-008 Arbitration: data SHALL have priority over instruction; a simultaneous data and fetch request in IDLE SHALL serve data first and fetch next.
REQ-009 If dREN and dWEN are both high, the request SHALL be served as a write and err SHALL be set.
REQ-010 In DREQ/IREQ, ramaddr, ramstore, ramREN and ramWEN SHALL come only from latched registers; in every other state all four SHALL be 0.
REQ-011 In DREQ/IREQ, ramstate==ACCESS SHALL capture ramload into dload (read only) or iload, then move to DDONE/IDONE.
REQ-012 DDONE/IDONE SHALL last exactly one cycle, then return to IDLE.
REQ-013 dwait SHALL be (dREN|dWEN) && state!=DDONE; iwait SHALL be iREN && state!=IDONE (combinational).
REQ-014 Minimum latency: request in IDLE at cycle 0 with ACCESS on the first DREQ cycle SHALL give wait low at cycle 2.
REQ-015 A write SHALL leave dload unchanged.
REQ-016 A 8-bit timeout counter SHALL clear on entry to DREQ/IREQ and increment each cycle in those states while ramstate!=ACCESS, saturating at 255.
REQ-017 At count 255, or on ramstate==ERROR, the block SHALL load 0xBAD1BAD1 into dload/iload, set err, and go to DDONE/IDONE.
REQ-018 If the requester drops its request in DREQ/IREQ, the RAM transaction SHALL still complete; the block SHALL go straight to IDLE with no DONE cycle and discard the result.
REQ-019 err SHALL clear only on reset.

Reset
REQ-020 On nRST low, the block SHALL immediately set state=IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0, dload=iload=0, counter=0 and err=0, independent of CLK.
REQ-021 Reset asserted mid-transaction SHALL abort the transaction; after reset releases, the block SHALL resume in IDLE with no completion cycle.

Verification
REQ-022 Read: dREN=1, daddr=0x40, ACCESS on the first DREQ cycle with ramload=0x1234 -> ramREN=1 at cycle 1, dload=0x1234 and dwait=0 at cycle 2.
REQ-023 Contention: dWEN=1 and iREN=1 together -> write to daddr first, then fetch; iwait stays 1 until IDONE.
REQ-024 Timeout: iREN=1 with ramstate held at BUSY -> IDONE after 256 IREQ cycles, iload=0xBAD1BAD1, err=1 (sticky).
REQ-025 Both enables: dREN=dWEN=1, dstore=0xAA -> ramWEN=1, ramREN=0, ramstore=0xAA, err=1.
REQ-026 Reset mid-DREQ: nRST low while ramstate=BUSY -> ramREN=0 in the same cycle; after release, a new dREN gets a normal 2-cycle completion.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU data/fetch and RAM side bus bundle for mem_arbiter
interface mem_arbiter_if;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    // slave: the arbiter's own view of the bus
    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between CPU data and fetch sides
module mem_arbiter (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus,
    output logic          err
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DREQ  = 3'd1,
        DDONE = 3'd2,
        IREQ  = 3'd3,
        IDONE = 3'd4
    } state_t;

    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [7:0]  COUNT_MAX  = 8'hFF;
    localparam logic [31:0] FAULT_WORD = 32'hBAD1BAD1;

    state_t      state, next_state;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic        wr_q;
    logic        drop_q;
    logic [7:0]  count_q;
    logic [31:0] dload_q;
    logic [31:0] iload_q;
    logic        err_q;

    logic dreq_any;
    logic in_req;
    logic req_live;
    logic keep;
    logic xfer_done;
    logic xfer_fault;

    assign dreq_any   = bus.dREN | bus.dWEN;
    assign in_req     = (state == DREQ) || (state == IREQ);
    assign req_live   = (state == DREQ) ? dreq_any : bus.iREN;
    // once the requester lets go, the result is discarded even if it re-asserts
    assign keep       = req_live && !drop_q;
    assign xfer_done  = (bus.ramstate == RAM_ACCESS);
    assign xfer_fault = !xfer_done && ((bus.ramstate == RAM_ERROR) || (count_q == COUNT_MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq_any) begin
                    next_state = DREQ;
                end else if (bus.iREN) begin
                    next_state = IREQ;
                end
            end
            DREQ: begin
                if (xfer_done || xfer_fault) begin
                    next_state = keep ? DDONE : IDLE;
                end
            end
            IREQ: begin
                if (xfer_done || xfer_fault) begin
                    next_state = keep ? IDONE : IDLE;
                end
            end
            DDONE:   next_state = IDLE;
            IDONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            drop_q  <= 1'b0;
            count_q <= '0;
            dload_q <= '0;
            iload_q <= '0;
            err_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (dreq_any) begin
                addr_q  <= bus.daddr;
                store_q <= bus.dstore;
                wr_q    <= bus.dWEN;
                drop_q  <= 1'b0;
                count_q <= '0;
                if (bus.dREN && bus.dWEN) begin
                    err_q <= 1'b1;
                end
            end else if (bus.iREN) begin
                addr_q  <= bus.iaddr;
                store_q <= '0;
                wr_q    <= 1'b0;
                drop_q  <= 1'b0;
                count_q <= '0;
            end
        end else if (in_req) begin
            if (!xfer_done && (count_q != COUNT_MAX)) begin
                count_q <= count_q + 8'd1;
            end
            if (!req_live) begin
                drop_q <= 1'b1;
            end
            if (xfer_done && keep) begin
                if (state == IREQ) begin
                    iload_q <= bus.ramload;
                end else if (!wr_q) begin
                    dload_q <= bus.ramload;
                end
            end
            if (xfer_fault) begin
                err_q <= 1'b1;
                if (keep) begin
                    if (state == IREQ) begin
                        iload_q <= FAULT_WORD;
                    end else begin
                        dload_q <= FAULT_WORD;
                    end
                end
            end
        end
    end

    // RAM strobes decode straight from state so an async reset drops them at once
    assign bus.ramREN   = ((state == DREQ) && !wr_q) || (state == IREQ);
    assign bus.ramWEN   = (state == DREQ) && wr_q;
    assign bus.ramaddr  = in_req ? addr_q : '0;
    assign bus.ramstore = (state == DREQ) ? store_q : '0;

    assign bus.dwait = dreq_any && (state != DDONE);
    assign bus.iwait = bus.iREN && (state != IDONE);
    assign bus.dload = dload_q;
    assign bus.iload = iload_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic CLK;
    logic nRST;
    logic err;
    int   errors;
    int   checks;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus),
        .err  (err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST         = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.ramload  = '0;
        bus.ramstate = 2'd0;
        #2;
        check("rst_ramREN", bus.ramREN, 0);
        check("rst_ramWEN", bus.ramWEN, 0);
        check("rst_ramaddr", bus.ramaddr, 0);
        check("rst_dload", bus.dload, 0);
        check("rst_iload", bus.iload, 0);
        check("rst_err", err, 0);
        tick();
        tick();
        nRST = 1'b1;
        tick();

        // plain read, ACCESS on first DREQ cycle
        bus.dREN = 1'b1;
        bus.daddr = 32'h40;
        #1;
        check("rd_dwait_c0", bus.dwait, 1);
        tick();
        check("rd_ramREN_c1", bus.ramREN, 1);
        check("rd_ramWEN_c1", bus.ramWEN, 0);
        check("rd_ramaddr_c1", bus.ramaddr, 32'h40);
        bus.ramstate = 2'd2;
        bus.ramload = 32'h1234;
        tick();
        check("rd_dload_c2", bus.dload, 32'h1234);
        check("rd_dwait_c2", bus.dwait, 0);
        check("rd_ramREN_c2", bus.ramREN, 0);
        bus.dREN = 1'b0;
        bus.ramstate = 2'd0;
        tick();

        // write and fetch together: data first
        bus.dWEN = 1'b1;
        bus.daddr = 32'h80;
        bus.dstore = 32'h55;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h100;
        bus.ramstate = 2'd1;
        tick();
        check("ct_ramWEN", bus.ramWEN, 1);
        check("ct_ramREN", bus.ramREN, 0);
        check("ct_ramaddr_d", bus.ramaddr, 32'h80);
        check("ct_ramstore", bus.ramstore, 32'h55);
        check("ct_iwait_dreq", bus.iwait, 1);
        bus.ramstate = 2'd2;
        bus.ramload = 32'hFFFF;
        tick();
        check("ct_dwait_ddone", bus.dwait, 0);
        check("ct_dload_unchanged", bus.dload, 32'h1234);
        check("ct_iwait_ddone", bus.iwait, 1);
        bus.dWEN = 1'b0;
        bus.ramstate = 2'd1;
        tick();
        check("ct_idle_ramREN", bus.ramREN, 0);
        check("ct_iwait_idle", bus.iwait, 1);
        tick();
        check("ct_ireq_ramREN", bus.ramREN, 1);
        check("ct_ireq_ramaddr", bus.ramaddr, 32'h100);
        check("ct_ireq_ramWEN", bus.ramWEN, 0);
        bus.ramstate = 2'd2;
        bus.ramload = 32'hCAFE;
        tick();
        check("ct_iload", bus.iload, 32'hCAFE);
        check("ct_iwait_idone", bus.iwait, 0);
        bus.iREN = 1'b0;
        bus.ramstate = 2'd0;
        tick();
        check("ct_err_clear", err, 0);

        // requester drops mid-transaction: result discarded, no DONE cycle
        bus.dREN = 1'b1;
        bus.daddr = 32'h200;
        bus.ramstate = 2'd1;
        tick();
        bus.dREN = 1'b0;
        tick();
        check("drop_still_dreq", bus.ramREN, 1);
        bus.ramstate = 2'd2;
        bus.ramload = 32'hDEAD;
        tick();
        check("drop_idle_ramREN", bus.ramREN, 0);
        check("drop_dload_kept", bus.dload, 32'h1234);
        bus.dREN = 1'b1;
        bus.daddr = 32'h204;
        bus.ramload = 32'h5555;
        tick();
        check("drop_next_ramREN", bus.ramREN, 1);
        check("drop_next_ramaddr", bus.ramaddr, 32'h204);
        tick();
        check("drop_next_dload", bus.dload, 32'h5555);
        bus.dREN = 1'b0;
        bus.ramstate = 2'd0;
        tick();

        // both enables: served as write, err set
        bus.dREN = 1'b1;
        bus.dWEN = 1'b1;
        bus.daddr = 32'h300;
        bus.dstore = 32'hAA;
        bus.ramstate = 2'd1;
        tick();
        check("both_ramWEN", bus.ramWEN, 1);
        check("both_ramREN", bus.ramREN, 0);
        check("both_ramstore", bus.ramstore, 32'hAA);
        check("both_err", err, 1);
        nRST = 1'b0;
        #1;
        check("both_rst_ramWEN", bus.ramWEN, 0);
        check("both_rst_err", err, 0);
        check("both_rst_dload", bus.dload, 0);
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        nRST = 1'b1;
        tick();

        // reset mid-DREQ, then a clean 2-cycle read
        bus.dREN = 1'b1;
        bus.daddr = 32'h44;
        tick();
        check("rq_ramREN_pre", bus.ramREN, 1);
        nRST = 1'b0;
        #1;
        check("rq_ramREN_rst", bus.ramREN, 0);
        check("rq_ramaddr_rst", bus.ramaddr, 0);
        nRST = 1'b1;
        #1;
        check("rq_dwait_idle", bus.dwait, 1);
        tick();
        check("rq_ramREN_c1", bus.ramREN, 1);
        check("rq_ramaddr_c1", bus.ramaddr, 32'h44);
        bus.ramstate = 2'd2;
        bus.ramload = 32'h7777;
        tick();
        check("rq_dload_c2", bus.dload, 32'h7777);
        check("rq_dwait_c2", bus.dwait, 0);
        bus.dREN = 1'b0;
        bus.ramstate = 2'd0;
        tick();

        // fetch timeout with RAM stuck BUSY: 256 IREQ cycles then IDONE
        bus.iREN = 1'b1;
        bus.iaddr = 32'h500;
        bus.ramstate = 2'd1;
        tick();
        check("to_ramaddr", bus.ramaddr, 32'h500);
        repeat (255) tick();
        check("to_last_ramREN", bus.ramREN, 1);
        check("to_last_iwait", bus.iwait, 1);
        tick();
        check("to_iload", bus.iload, 32'hBAD1BAD1);
        check("to_iwait", bus.iwait, 0);
        check("to_err", err, 1);
        check("to_ramREN", bus.ramREN, 0);
        bus.iREN = 1'b0;
        tick();
        check("to_err_sticky", err, 1);

        // RAM ERROR on a data read
        bus.dREN = 1'b1;
        bus.daddr = 32'h600;
        bus.ramstate = 2'd3;
        tick();
        tick();
        check("re_dload", bus.dload, 32'hBAD1BAD1);
        check("re_dwait", bus.dwait, 0);
        bus.dREN = 1'b0;
        bus.ramstate = 2'd0;
        tick();
        check("re_err_sticky", err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
